xm_mem_arbiter: RTL and testbench
=================================

Name: xm_mem_arbiter

Overview:
- Shares the single-port data memory between three requesters: CPU instruction fetch, CPU data access and the debugger memory port.
- Sits between the CPU/debugger and the memory block, and owns the memory enable, write-enable, address and data lines.
- Each request is latched, run as one memory transaction of fixed latency, then acknowledged with a one-cycle ack pulse.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset; asynchronous, active-low.
- fReq_i, dReq_i, gReq_i  in  1 each  request from fetch / data / debugger.
- fAddr_i, dAddr_i, gAddr_i  in  ADDR_W each  request address.
- dWe_i, gWe_i  in  1 each  write request (fetch is read-only).
- dData_i, gData_i  in  DATA_W each  write data.
- fAck_o, dAck_o, gAck_o  out  1 each  transaction complete (one-cycle pulse).
- rdata_o  out  DATA_W  read data, shared by all requesters.
- busy_o  out  1  high whenever state is not IDLE.
- memEn_o, memWe_o  out  1 each  memory enable / write enable.
- memAddr_o  out  ADDR_W  memory address.
- memData_o  out  DATA_W  memory write data.
- mem_i  in  DATA_W  memory read data, valid MEM_LAT cycles after the first enabled cycle.

Behaviour:
- States: IDLE, ACCESS, ACK.
- Reset (arstn_i low, asynchronous, any state, including mid-transaction):
  - state goes to IDLE; the in-flight transaction is dropped with no ack.
  - All outputs are 0, including the rdata hold register.
  - rr_q = 0 (the next CPU tie goes to fetch).
- IDLE, no request: stay in IDLE.
- IDLE, any request present:
  - Winner selection: gReq_i has absolute priority. Otherwise fetch and data are round-robin on rr_q: rr_q = 0 favours fetch, rr_q = 1 favours data. A lone requester always wins.
  - Latch owner, addr, we (0 for fetch) and wdata into registers.
  - If a CPU port won, rr_q toggles to the other CPU port.
  - Next state is ACCESS.
- ACCESS:
  - memEn_o = 1; memWe_o = we_q; memAddr_o = addr_q; memData_o = wdata_q. These are held stable for every ACCESS cycle.
  - A write lasts 1 cycle. A read lasts MEM_LAT cycles, timed by a down-counter loaded with MEM_LAT-1.
  - When the count expires (or immediately for a write), go to ACK.
- ACK:
  - The owner's ack is high for exactly 1 cycle; all memory outputs are 0.
  - rdata_o = mem_i combinationally. At the end of ACK, mem_i is captured into the hold register.
  - Outside ACK, rdata_o = hold register; it is unchanged by writes.
  - Next state is always IDLE (one bubble cycle between transactions).
- Latency from the request-sampled IDLE cycle t:
  - Read: ack at t+MEM_LAT+1.
  - Write: ack at t+2.
- Requester rules:
  - Hold req, addr, we and data stable until ack.
  - Drop req in the cycle after ack, otherwise it is a new request.
  - Withdrawing req before it is latched cancels it silently. Changes after latching have no effect.
- Simultaneous events:
  - All three requesting: debugger first.
  - Fetch and data both pending: they alternate strictly.
  - A request arriving during ACCESS or ACK waits for IDLE.
- Starvation: the CPU may be starved while the debugger requests continuously. This is permitted, because the debugger only issues accesses while the CPU is halted.
- Debugger write data path: gWe_i = 1 writes gData_i at gAddr_i (sourced from the debugger's memAddr/memData registers).

Test Plan:
- Reset, then fReq_i = 1 with fAddr_i = 0x0010, MEM_LAT = 1, mem_i = 0xBEEF in the ACK cycle.
  -> memEn_o = 1 and memAddr_o = 0x0010 in cycle 1; fAck_o = 1 and rdata_o = 0xBEEF in cycle 2; rdata_o stays 0xBEEF afterwards.
- dReq_i = 1, dWe_i = 1, dAddr_i = 0x0200, dData_i = 0x1234.
  -> one ACCESS cycle with memWe_o = 1, memData_o = 0x1234; dAck_o in cycle 2; rdata_o unchanged.
- fReq_i, dReq_i and gReq_i all asserted at once, each held until its ack, then dropped.
  -> grants in order g, f, d; each ack is a 1-cycle pulse with one IDLE cycle between transactions.
- fReq_i and dReq_i held continuously for 4 transactions.
  -> grant order f, d, f, d; no port is acked twice in a row.
- MEM_LAT = 3, read from gAddr_i = 0x00FF.
  -> memEn_o high for exactly 3 cycles; gAck_o in cycle 4.
- arstn_i pulsed low during the second ACCESS cycle of a MEM_LAT = 3 read.
  -> all outputs 0 immediately; no ack issued; the next request (fetch-first tie) is served normally.

Source files
------------

// File: rtl/xm_mem_arbiter_if.sv
// xm_mem_arbiter_if: requester and memory-side signal bundle for the memory arbiter
//   fReq_i/dReq_i/gReq_i, *Addr_i, dWe_i/gWe_i, dData_i/gData_i : fetch/data/debugger requests
//   fAck_o/dAck_o/gAck_o : one-cycle completion pulses, rdata_o shared read data, busy_o
//   memEn_o/memWe_o/memAddr_o/memData_o : memory control, mem_i : memory read data
//   slave modport is the arbiter's view, master modport is the requester/memory view
interface xm_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              fReq_i, dReq_i, gReq_i;
    logic [ADDR_W-1:0] fAddr_i, dAddr_i, gAddr_i;
    logic              dWe_i, gWe_i;
    logic [DATA_W-1:0] dData_i, gData_i;
    logic              fAck_o, dAck_o, gAck_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              memEn_o, memWe_o;
    logic [ADDR_W-1:0] memAddr_o;
    logic [DATA_W-1:0] memData_o;
    logic [DATA_W-1:0] mem_i;

    modport slave (
        input  fReq_i, dReq_i, gReq_i, fAddr_i, dAddr_i, gAddr_i,
               dWe_i, gWe_i, dData_i, gData_i, mem_i,
        output fAck_o, dAck_o, gAck_o, rdata_o, busy_o,
               memEn_o, memWe_o, memAddr_o, memData_o
    );

    modport master (
        output fReq_i, dReq_i, gReq_i, fAddr_i, dAddr_i, gAddr_i,
               dWe_i, gWe_i, dData_i, gData_i, mem_i,
        input  fAck_o, dAck_o, gAck_o, rdata_o, busy_o,
               memEn_o, memWe_o, memAddr_o, memData_o
    );
endinterface

// File: rtl/xm_mem_arbiter.sv
// xm_mem_arbiter: shares one single-port memory between CPU fetch, CPU data and debugger
//   clk_i   : clock
//   arstn_i : asynchronous active-low reset
//   bus     : xm_mem_arbiter_if slave modport (requests, acks, read data, memory control)
module xm_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input logic              clk_i,
    input logic              arstn_i,
    xm_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic [1:0] {OWN_F, OWN_D, OWN_G} owner_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, win;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, hold_q;
    logic              we_q, rr_q, any_req;
    logic [1:0]        cnt_q;

    // debugger always wins; fetch/data tie resolved by rr_q (0 favours fetch)
    always_comb begin
        any_req = bus.fReq_i | bus.dReq_i | bus.gReq_i;
        win     = bus.gReq_i ? OWN_G : (bus.fReq_i && (!bus.dReq_i || !rr_q)) ? OWN_F : OWN_D;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // writes leave ACCESS after one cycle; reads wait for the latency counter
    always_comb begin
        state_d = state_q == IDLE   ? (any_req ? ACCESS : IDLE) :
                  state_q == ACCESS ? ((we_q || cnt_q == 2'd0) ? ACK : ACCESS) : IDLE;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            owner_q <= OWN_F;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q <= win;
                addr_q  <= win == OWN_G ? bus.gAddr_i : win == OWN_F ? bus.fAddr_i : bus.dAddr_i;
                we_q    <= win == OWN_G ? bus.gWe_i : win == OWN_D ? bus.dWe_i : 1'b0;
                wdata_q <= win == OWN_G ? bus.gData_i : bus.dData_i;
                cnt_q   <= CNT_INIT;
                if (win != OWN_G)
                    rr_q <= win == OWN_F;
            end
            if (state_q == ACCESS && cnt_q != 2'd0)
                cnt_q <= cnt_q - 2'd1;
            // only reads refresh the read-data hold register
            if (state_q == ACK && !we_q)
                hold_q <= bus.mem_i;
        end
    end

    always_comb begin
        bus.busy_o    = state_q != IDLE;
        bus.memEn_o   = state_q == ACCESS;
        bus.memWe_o   = state_q == ACCESS && we_q;
        bus.memAddr_o = state_q == ACCESS ? addr_q : '0;
        bus.memData_o = state_q == ACCESS ? wdata_q : '0;
        bus.fAck_o    = state_q == ACK && owner_q == OWN_F;
        bus.dAck_o    = state_q == ACK && owner_q == OWN_D;
        bus.gAck_o    = state_q == ACK && owner_q == OWN_G;
        bus.rdata_o   = state_q == ACK ? bus.mem_i : hold_q;
    end
endmodule

// File: tb/tb_xm_mem_arbiter.sv
// tb_xm_mem_arbiter: directed-vector bench for xm_mem_arbiter at MEM_LAT 1 and 3
module tb_xm_mem_arbiter;
    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    xm_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    xm_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

    xm_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (.clk_i(clk_i), .arstn_i(arstn_i), .bus(b1.slave));
    xm_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u3 (.clk_i(clk_i), .arstn_i(arstn_i), .bus(b3.slave));

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        b1.fReq_i = 0; b1.dReq_i = 0; b1.gReq_i = 0;
        b1.fAddr_i = 0; b1.dAddr_i = 0; b1.gAddr_i = 0;
        b1.dWe_i = 0; b1.gWe_i = 0; b1.dData_i = 0; b1.gData_i = 0; b1.mem_i = 0;
        b3.fReq_i = 0; b3.dReq_i = 0; b3.gReq_i = 0;
        b3.fAddr_i = 0; b3.dAddr_i = 0; b3.gAddr_i = 0;
        b3.dWe_i = 0; b3.gWe_i = 0; b3.dData_i = 0; b3.gData_i = 0; b3.mem_i = 0;
    endtask

    task automatic test_reset();
        arstn_i = 0;
        clear_inputs();
        #22;
        smp();
        vectors++; if (b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", b1.busy_o); end
        vectors++; if (b1.memEn_o !== 1'b0 || b1.memWe_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ctl: got en=%b we=%b expected 0 0", b1.memEn_o, b1.memWe_o); end
        vectors++; if (b1.memAddr_o !== 16'h0 || b1.memData_o !== 16'h0) begin miscompares++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0 0", b1.memAddr_o, b1.memData_o); end
        vectors++; if ({b1.fAck_o, b1.dAck_o, b1.gAck_o} !== 3'b000) begin miscompares++; $display("FAIL reset_acks: got %b expected 000", {b1.fAck_o, b1.dAck_o, b1.gAck_o}); end
        vectors++; if (b1.rdata_o !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0000", b1.rdata_o); end
        vectors++; if (b3.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy_lat3: got %b expected 0", b3.busy_o); end
        arstn_i = 1;
    endtask

    task automatic test_fetch_read();
        cyc();
        b1.fReq_i = 1; b1.fAddr_i = 16'h0010;
        smp();
        vectors++; if (b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL fetch_c0_busy: got %b expected 0", b1.busy_o); end
        cyc();
        smp();
        vectors++; if (b1.memEn_o !== 1'b1 || b1.memWe_o !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_ctl: got en=%b we=%b expected 1 0", b1.memEn_o, b1.memWe_o); end
        vectors++; if (b1.memAddr_o !== 16'h0010) begin miscompares++; $display("FAIL fetch_c1_addr: got %h expected 0010", b1.memAddr_o); end
        vectors++; if (b1.fAck_o !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_ack: got %b expected 0", b1.fAck_o); end
        cyc();
        b1.mem_i = 16'hBEEF;
        smp();
        vectors++; if (b1.fAck_o !== 1'b1 || b1.memEn_o !== 1'b0) begin miscompares++; $display("FAIL fetch_c2_ack: got ack=%b en=%b expected 1 0", b1.fAck_o, b1.memEn_o); end
        vectors++; if (b1.rdata_o !== 16'hBEEF) begin miscompares++; $display("FAIL fetch_c2_rdata: got %h expected beef", b1.rdata_o); end
        cyc();
        b1.fReq_i = 0; b1.mem_i = 16'h0000;
        smp();
        vectors++; if (b1.fAck_o !== 1'b0 || b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL fetch_c3_idle: got ack=%b busy=%b expected 0 0", b1.fAck_o, b1.busy_o); end
        vectors++; if (b1.rdata_o !== 16'hBEEF) begin miscompares++; $display("FAIL fetch_c3_hold: got %h expected beef", b1.rdata_o); end
    endtask

    task automatic test_data_write();
        cyc();
        b1.dReq_i = 1; b1.dWe_i = 1; b1.dAddr_i = 16'h0200; b1.dData_i = 16'h1234;
        smp();
        vectors++; if (b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL write_c0_busy: got %b expected 0", b1.busy_o); end
        cyc();
        smp();
        vectors++; if (b1.memEn_o !== 1'b1 || b1.memWe_o !== 1'b1) begin miscompares++; $display("FAIL write_c1_ctl: got en=%b we=%b expected 1 1", b1.memEn_o, b1.memWe_o); end
        vectors++; if (b1.memAddr_o !== 16'h0200 || b1.memData_o !== 16'h1234) begin miscompares++; $display("FAIL write_c1_bus: got addr=%h data=%h expected 0200 1234", b1.memAddr_o, b1.memData_o); end
        cyc();
        b1.mem_i = 16'h5555;
        smp();
        vectors++; if (b1.dAck_o !== 1'b1 || b1.memEn_o !== 1'b0 || b1.memWe_o !== 1'b0) begin miscompares++; $display("FAIL write_c2_ack: got ack=%b en=%b we=%b expected 1 0 0", b1.dAck_o, b1.memEn_o, b1.memWe_o); end
        cyc();
        b1.dReq_i = 0; b1.dWe_i = 0; b1.mem_i = 16'h0000;
        smp();
        vectors++; if (b1.dAck_o !== 1'b0 || b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL write_c3_idle: got ack=%b busy=%b expected 0 0", b1.dAck_o, b1.busy_o); end
        vectors++; if (b1.rdata_o !== 16'hBEEF) begin miscompares++; $display("FAIL write_rdata_kept: got %h expected beef", b1.rdata_o); end
    endtask

    task automatic test_three_way();
        int order[3] = '{3, 3, 3};
        int at[3] = '{-1, -1, -1};
        int exp_order[3] = '{2, 0, 1};
        int n = 0;
        logic [2:0] a;
        logic prev = 0;
        cyc();
        b1.fReq_i = 1; b1.fAddr_i = 16'h0100;
        b1.dReq_i = 1; b1.dAddr_i = 16'h0101;
        b1.gReq_i = 1; b1.gAddr_i = 16'h0102;
        for (int c = 0; c < 30 && n < 3; c++) begin
            smp();
            a = {b1.gAck_o, b1.dAck_o, b1.fAck_o};
            if (prev) begin
                vectors++; if (b1.busy_o !== 1'b0) begin miscompares++; $display("FAIL three_bubble: cycle %0d got busy=%b expected 0", c, b1.busy_o); end
            end
            vectors++; if ($countones(a) > 1) begin miscompares++; $display("FAIL three_onehot: cycle %0d got acks=%b expected at most one", c, a); end
            prev = a != 3'b000;
            if (a != 3'b000) begin
                order[n] = a == 3'b100 ? 2 : a == 3'b010 ? 1 : a == 3'b001 ? 0 : 3;
                at[n] = c;
                n++;
            end
            cyc();
            if (a[0]) b1.fReq_i = 0;
            if (a[1]) b1.dReq_i = 0;
            if (a[2]) b1.gReq_i = 0;
        end
        vectors++; if (n != 3) begin miscompares++; $display("FAIL three_count: got %0d acks expected 3", n); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (order[i] != exp_order[i] || at[i] != 2 + 3 * i) begin miscompares++; $display("FAIL three_grant%0d: got port=%0d cycle=%0d expected port=%0d cycle=%0d", i, order[i], at[i], exp_order[i], 2 + 3 * i); end
        end
        b1.fReq_i = 0; b1.dReq_i = 0; b1.gReq_i = 0;
    endtask

    task automatic test_cpu_alternate();
        int order[4] = '{3, 3, 3, 3};
        int at[4] = '{-1, -1, -1, -1};
        int n = 0;
        logic [2:0] a;
        cyc();
        b1.fReq_i = 1; b1.fAddr_i = 16'h0300;
        b1.dReq_i = 1; b1.dAddr_i = 16'h0400;
        for (int c = 0; c < 40 && n < 4; c++) begin
            smp();
            a = {b1.gAck_o, b1.dAck_o, b1.fAck_o};
            if (a != 3'b000) begin
                order[n] = a == 3'b001 ? 0 : a == 3'b010 ? 1 : 3;
                at[n] = c;
                n++;
            end
            cyc();
            if (n == 4) begin b1.fReq_i = 0; b1.dReq_i = 0; end
        end
        b1.fReq_i = 0; b1.dReq_i = 0;
        vectors++; if (n != 4) begin miscompares++; $display("FAIL alt_count: got %0d acks expected 4", n); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (order[i] != i % 2 || at[i] != 2 + 3 * i) begin miscompares++; $display("FAIL alt_grant%0d: got port=%0d cycle=%0d expected port=%0d cycle=%0d", i, order[i], at[i], i % 2, 2 + 3 * i); end
        end
    endtask

    task automatic test_lat3_read();
        int en_cnt = 0;
        int ack_cnt = 0;
        int ack_at = -1;
        cyc();
        b3.gReq_i = 1; b3.gWe_i = 0; b3.gAddr_i = 16'h00FF; b3.mem_i = 16'hCAFE;
        for (int c = 0; c < 8; c++) begin
            smp();
            if (b3.memEn_o) begin
                en_cnt++;
                vectors++; if (b3.memAddr_o !== 16'h00FF) begin miscompares++; $display("FAIL lat3_addr: cycle %0d got %h expected 00ff", c, b3.memAddr_o); end
            end
            if (b3.gAck_o) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = c;
                vectors++; if (b3.rdata_o !== 16'hCAFE) begin miscompares++; $display("FAIL lat3_rdata: got %h expected cafe", b3.rdata_o); end
            end
            cyc();
            if (ack_at >= 0) b3.gReq_i = 0;
        end
        vectors++; if (en_cnt != 3) begin miscompares++; $display("FAIL lat3_en_cycles: got %0d expected 3", en_cnt); end
        vectors++; if (ack_at != 4 || ack_cnt != 1) begin miscompares++; $display("FAIL lat3_ack: got cycle=%0d count=%0d expected cycle=4 count=1", ack_at, ack_cnt); end
        smp();
        vectors++; if (b3.rdata_o !== 16'hCAFE) begin miscompares++; $display("FAIL lat3_hold: got %h expected cafe", b3.rdata_o); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        int f_at = -1;
        int d_seen = 0;
        cyc();
        b3.mem_i = 16'h0000; b3.fReq_i = 1; b3.fAddr_i = 16'h0040;
        cyc();
        cyc();
        vectors++; if (b3.memEn_o !== 1'b1) begin miscompares++; $display("FAIL mid_access: got en=%b expected 1", b3.memEn_o); end
        arstn_i = 0;
        #1;
        vectors++; if (b3.memEn_o !== 1'b0 || b3.busy_o !== 1'b0) begin miscompares++; $display("FAIL mid_async: got en=%b busy=%b expected 0 0", b3.memEn_o, b3.busy_o); end
        vectors++; if (b3.memAddr_o !== 16'h0 || b3.rdata_o !== 16'h0) begin miscompares++; $display("FAIL mid_bus: got addr=%h rdata=%h expected 0000 0000", b3.memAddr_o, b3.rdata_o); end
        vectors++; if ({b3.fAck_o, b3.dAck_o, b3.gAck_o} !== 3'b000) begin miscompares++; $display("FAIL mid_acks: got %b expected 000", {b3.fAck_o, b3.dAck_o, b3.gAck_o}); end
        b3.fReq_i = 0;
        smp();
        arstn_i = 1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            smp();
            if (b3.fAck_o || b3.dAck_o || b3.gAck_o || b3.busy_o) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL mid_no_ack: got %0d active cycles expected 0", stray); end
        cyc();
        b3.fReq_i = 1; b3.fAddr_i = 16'h0050;
        b3.dReq_i = 1; b3.dAddr_i = 16'h0060;
        for (int c = 0; c < 20 && d_seen == 0; c++) begin
            smp();
            if (b3.dAck_o && f_at < 0) begin
                vectors++; miscompares++; $display("FAIL mid_tie: got data first expected fetch first");
            end
            if (b3.fAck_o && f_at < 0) f_at = c;
            if (b3.dAck_o) d_seen = 1;
            cyc();
            if (f_at >= 0) b3.fReq_i = 0;
            if (d_seen != 0) b3.dReq_i = 0;
        end
        vectors++; if (f_at != 4 || d_seen != 1) begin miscompares++; $display("FAIL mid_after: got fetch ack cycle=%0d data acked=%0d expected 4 1", f_at, d_seen); end
        b3.fReq_i = 0; b3.dReq_i = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_write();
        test_three_way();
        test_cpu_alternate();
        test_lat3_read();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
